// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode/execute controller for the mrhankey 8-bit CPU.
// Owns pc and ir, fetches program bytes over a mem_rd/mem_valid handshake,
// strobes exec_en for one cycle per instruction, and stops on HALT (8'hFF)
// or on a fetch timeout.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the step input and the
// PAUSE state (one instruction per rising edge of step).
module fetch_sequencer #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic [7:0]        ir,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_en,
  output logic              halted,
  output logic              bus_err,
  output logic [CNT_W-1:0]  retired,
  output logic [2:0]        state
);

  localparam int unsigned TMR_W = 8;
  localparam logic [7:0]  OP_HALT = 8'hFF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
`ifdef SEQ_SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE  = 3'd5;
`endif

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  logic [TMR_W-1:0]  r_timer;
  logic              r_bus_err;
  logic [CNT_W-1:0]  r_retired;
  logic              r_mem_rd;
  logic              r_exec_en;
  logic              r_halted;

  logic [2:0]        w_next_state;
  logic [TMR_W-1:0]  w_timer_inc;
  logic              w_timeout;
  logic              w_mem_rd_d;
  logic              w_exec_en_d;
  logic              w_halted_d;

`ifdef SEQ_SINGLE_STEP_EN
  logic              r_step_prev;
  logic              w_step_rise;

  assign w_step_rise = step & ~r_step_prev;

  // Previous step level, for rising-edge detection.
  always_ff @(posedge clk) begin
    if (clr) r_step_prev <= 1'b0;
    else     r_step_prev <= step;
  end
`endif

  // The timer counts FETCH cycles; the TIMEOUT-th cycle without data aborts.
  assign w_timer_inc = r_timer + TMR_W'(1);
  assign w_timeout   = (w_timer_inc >= TMR_W'(TIMEOUT));

  // State register; clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_mem_rd  <= 1'b0;
      r_exec_en <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_mem_rd  <= w_mem_rd_d;
      r_exec_en <= w_exec_en_d;
      r_halted  <= w_halted_d;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:   w_next_state = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (mem_valid)      w_next_state = S_DECODE;
        else if (w_timeout) w_next_state = S_HALTED;
        else                w_next_state = S_FETCH;
      end
      S_DECODE: w_next_state = (r_ir == OP_HALT) ? S_HALTED : S_EXEC;
`ifdef SEQ_SINGLE_STEP_EN
      S_EXEC:   w_next_state = S_PAUSE;
      S_PAUSE: begin
        if (!run)             w_next_state = S_IDLE;
        else if (w_step_rise) w_next_state = S_FETCH;
        else                  w_next_state = S_PAUSE;
      end
`else
      S_EXEC:   w_next_state = run ? S_FETCH : S_IDLE;
`endif
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the next state so the flops line up with the state.
  always_comb begin
    w_mem_rd_d  = 1'b0;
    w_exec_en_d = 1'b0;
    w_halted_d  = 1'b0;
    case (w_next_state)
      S_FETCH:  w_mem_rd_d  = 1'b1;
      S_EXEC:   w_exec_en_d = 1'b1;
      S_HALTED: w_halted_d  = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: pc/ir load on accepted fetch, wait timer, error flag, retire count.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_timer   <= '0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        if (mem_valid) begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + ADDR_W'(1);
          r_timer <= '0;
        end else if (w_timeout) begin
          r_bus_err <= 1'b1;
          r_timer   <= '0;
        end else begin
          r_timer <= w_timer_inc;
        end
      end else begin
        r_timer <= '0;
      end
      if (r_state == S_EXEC) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign ir       = r_ir;
  assign exec_en  = r_exec_en;
  assign halted   = r_halted;
  assign bus_err  = r_bus_err;
  assign retired  = r_retired;
  assign state    = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a per-cycle reference model built from the
// instruction-sequencing rules, a memory responder with configurable wait
// states, directed scenarios with literal expectations, and a random phase.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 16;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CMOD  = 1 << CNT_W;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3,
                 ST_HALTED = 4, ST_PAUSE = 5;

  logic              clk;
  logic              clr;
  logic              run;
  logic              step;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_valid;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] pc;
  logic              exec_en;
  logic              halted;
  logic              bus_err;
  logic [CNT_W-1:0]  retired;
  logic [2:0]        state;

  fetch_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .ir(ir), .pc(pc), .exec_en(exec_en),
    .halted(halted), .bus_err(bus_err), .retired(retired), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_state = ST_IDLE;
  int       m_pc = 0;
  logic [7:0] m_ir = 8'h00;
  int       m_wait = 0;
  bit       m_bus_err = 0;
  int       m_retired = 0;
  bit       m_step_prev = 0;
  bit       step_mode;

  always @(posedge clk) begin
    cyc++;
    if (clr) begin
      m_state = ST_IDLE; m_pc = 0; m_ir = 8'h00; m_wait = 0;
      m_bus_err = 0; m_retired = 0;
    end else begin
      case (m_state)
        ST_IDLE: if (run) m_state = ST_FETCH;
        ST_FETCH: begin
          if (mem_valid) begin
            m_ir = mem_rdata;
            m_pc = (m_pc + 1) % DEPTH;
            m_wait = 0;
            m_state = ST_DECODE;
          end else begin
            m_wait++;
            if (m_wait >= TIMEOUT) begin
              m_bus_err = 1;
              m_state = ST_HALTED;
            end
          end
        end
        ST_DECODE: m_state = (m_ir == 8'hFF) ? ST_HALTED : ST_EXEC;
        ST_EXEC: begin
          m_retired = (m_retired + 1) % CMOD;
          if (step_mode)  m_state = ST_PAUSE;
          else            m_state = run ? ST_FETCH : ST_IDLE;
        end
        ST_PAUSE: begin
          if (!run)                     m_state = ST_IDLE;
          else if (step && !m_step_prev) m_state = ST_FETCH;
        end
        default: ;
      endcase
    end
    m_step_prev = clr ? 1'b0 : step;
    #1;
    check("state",    32'(state),    32'(m_state));
    check("pc",       32'(pc),       32'(m_pc));
    check("mem_addr", 32'(mem_addr), 32'(m_pc));
    check("ir",       32'(ir),       32'(m_ir));
    check("mem_rd",   32'(mem_rd),   32'(m_state == ST_FETCH));
    check("exec_en",  32'(exec_en),  32'(m_state == ST_EXEC));
    check("halted",   32'(halted),   32'(m_state == ST_HALTED));
    check("bus_err",  32'(bus_err),  32'(m_bus_err));
    check("retired",  32'(retired),  32'(m_retired));
  end

  // ---------------- memory responder ----------------
  logic [7:0] mem [DEPTH];
  int  fixed_wait = 0;
  bit  rand_wait  = 0;
  bit  mem_dead   = 0;
  bit  noise      = 0;
  int  wcnt       = 0;
  int  cur_wait   = 0;

  task automatic respond();
    if (mem_rd) begin
      if (wcnt == 0)
        cur_wait = rand_wait ? (($urandom_range(0, 31) == 0) ? 40 : int'($urandom_range(0, 3)))
                             : fixed_wait;
      if (!mem_dead && wcnt >= cur_wait) begin
        mem_valid = 1'b1;
        mem_rdata = mem[mem_addr];
        wcnt = 0;
      end else begin
        mem_valid = 1'b0;
        mem_rdata = 8'($urandom);
        wcnt++;
      end
    end else begin
      wcnt = 0;
      mem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 8'($urandom);
    end
  endtask

  // Advance one clock; inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
    respond();
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int a = 0; a < DEPTH; a++) mem[a] = v;
  endtask

`ifndef SEQ_SINGLE_STEP_EN
  // Straight-line program 05,6B,84,FF with a fixed wait count per fetch.
  task automatic run_program(input int waits);
    logic [7:0] prog [4];
    int n_ex;
    int last;
    prog[0] = 8'h05; prog[1] = 8'h6B; prog[2] = 8'h84; prog[3] = 8'hFF;
    fill_mem(8'h00);
    for (int a = 0; a < 4; a++) mem[a] = prog[a];
    fixed_wait = waits;
    do_reset();
    run = 1'b1;
    n_ex = 0;
    last = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (exec_en) begin
        if (n_ex > 0) check("exec_gap", 32'(i - last), 32'(waits + 3));
        if (n_ex < 3) check("exec_ir", 32'(ir), 32'(prog[n_ex]));
        last = i;
        n_ex++;
      end
      if (halted) break;
    end
    check("exec_count", 32'(n_ex), 32'd3);
    check("prog_halted", 32'(halted), 32'd1);
    check("prog_pc", 32'(pc), 32'd4);
    check("prog_retired", 32'(retired), 32'd3);
    check("prog_ir", 32'(ir), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      run = 1'($urandom_range(0, 1));
      tick();
    end
    check("halt_sticky", 32'(state), 32'd4);
    fixed_wait = 0;
  endtask
`endif

  initial begin
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b1;
`else
    step_mode = 1'b0;
`endif
    clr = 1'b1; run = 1'b0; step = 1'b0;
    mem_valid = 1'b0; mem_rdata = 8'h00;
    fill_mem(8'h00);

    // Reset then idle with run low.
    do_reset();
    repeat (10) tick();
    check("idle_state", 32'(state), 32'd0);
    check("idle_retired", 32'(retired), 32'd0);

`ifndef SEQ_SINGLE_STEP_EN
    run_program(0);
    run_program(2);
`endif

    // Memory never answers: abort after TIMEOUT fetch cycles.
    begin
      int n_rd;
      mem_dead = 1'b1;
      do_reset();
      run = 1'b1;
      n_rd = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (mem_rd) n_rd++;
        if (halted) break;
      end
      check("timeout_cycles", 32'(n_rd), 32'd15);
      check("timeout_bus_err", 32'(bus_err), 32'd1);
      check("timeout_halted", 32'(halted), 32'd1);
      check("timeout_pc", 32'(pc), 32'd0);
      mem_dead = 1'b0;
      run = 1'b0;
      do_reset();
      check("clr_state", 32'(state), 32'd0);
      check("clr_bus_err", 32'(bus_err), 32'd0);
    end

    // clr during a FETCH cycle that also has mem_valid.
    fill_mem(8'h05);
    do_reset();
    run = 1'b1;
    tick();
    check("midfetch_valid", 32'(mem_valid), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    run = 1'b0;
    check("midfetch_state", 32'(state), 32'd0);
    check("midfetch_ir", 32'(ir), 32'd0);
    check("midfetch_pc", 32'(pc), 32'd0);

`ifndef SEQ_SINGLE_STEP_EN
    // run dropped during DECODE: instruction completes, then IDLE.
    do_reset();
    run = 1'b1;
    tick();
    tick();
    check("drop_decode", 32'(state), 32'd2);
    run = 1'b0;
    tick();
    check("drop_exec", 32'(exec_en), 32'd1);
    tick();
    check("drop_state", 32'(state), 32'd0);
    check("drop_pc", 32'(pc), 32'd1);

    // PC wrap: 64th instruction executes with pc back at 0.
    begin
      int n_ex;
      fill_mem(8'h11);
      do_reset();
      run = 1'b1;
      n_ex = 0;
      for (int i = 0; i < 400 && n_ex < 64; i++) begin
        tick();
        if (exec_en) n_ex++;
      end
      check("wrap_count", 32'(n_ex), 32'd64);
      check("wrap_pc", 32'(pc), 32'd0);
      check("wrap_retired", 32'(retired), 32'd63);
    end

    // HALT at the last address.
    fill_mem(8'h11);
    mem[DEPTH-1] = 8'hFF;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 400 && !halted; i++) tick();
    check("lasthalt_halted", 32'(halted), 32'd1);
    check("lasthalt_pc", 32'(pc), 32'd0);
    check("lasthalt_retired", 32'(retired), 32'd63);
`else
    // Single-step: one instruction per step rising edge.
    begin
      int n_ex;
      fill_mem(8'h11);
      do_reset();
      run = 1'b1;
      n_ex = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (exec_en) n_ex++;
      end
      check("step_first", 32'(n_ex), 32'd1);
      check("step_pause", 32'(state), 32'd5);
      n_ex = 0;
      step = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (exec_en) n_ex++;
      end
      step = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (exec_en) n_ex++;
      end
      check("step_held", 32'(n_ex), 32'd1);
      run = 1'b0;
      tick();
      check("step_idle", 32'(state), 32'd0);
    end
`endif

    // Random phase: random program, waits, run, occasional clr and timeouts.
    for (int a = 0; a < DEPTH; a++)
      mem[a] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    rand_wait = 1'b1;
    noise = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run  = ($urandom_range(0, 7) != 0);
      clr  = ($urandom_range(0, 79) == 0);
      step = 1'($urandom_range(0, 1));
      tick();
    end
    clr = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the mrhankey 8-bit CPU.
- Owns the program counter and instruction register, and reads program bytes over a simple request/valid memory handshake.
- Presents the IR to the decode block and gates decode's register-load outputs with a one-cycle execute strobe.
- Stops on the HALT opcode (8'hFF) or on a memory timeout.

Parameters:
- ADDR_W, 6, program-counter and memory address width; PC wraps modulo 2^ADDR_W.
- TIMEOUT, 15, maximum cycles spent in FETCH waiting for mem_valid before aborting; legal range 1..255.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  synchronous, active-high reset.
- run  input  1  level; start or continue execution from IDLE.
- mem_rd  output  1  fetch request, held high until accepted.
- mem_addr  output  ADDR_W  fetch address; always equals pc.
- mem_rdata  input  8  fetched byte; sampled only when mem_valid=1 in FETCH.
- mem_valid  input  1  memory data valid; ignored outside FETCH.
- ir  output  8  instruction register, connected to decode IR.
- pc  output  ADDR_W  program counter.
- exec_en  output  1  one-cycle strobe; qualifies decode loadA/loadB.
- halted  output  1  high in HALTED state.
- bus_err  output  1  sticky; set on fetch timeout.
- retired  output  CNT_W  count of executed non-HALT instructions.
- state  output  3  state encoding, for debug.

Behaviour:
- Reset (clr=1 at a clock edge, in any state including mid-fetch):
  - state=IDLE, pc=0, ir=0, mem_rd=0, exec_en=0, halted=0, bus_err=0, retired=0, internal timer=0.
  - clr has priority over every other input.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALTED=4, PAUSE=5 (PAUSE exists only with the optional feature). Other encodings go to IDLE on the next edge.
- IDLE: outputs quiet. If run=1, go to FETCH on the next edge.
- FETCH:
  - mem_rd=1, mem_addr=pc, timer increments every cycle.
  - On mem_valid=1: ir<=mem_rdata, pc<=pc+1 (wraps), timer<=0, go to DECODE.
  - Zero-wait memory is legal: mem_valid in the first FETCH cycle gives one FETCH cycle.
  - If timer reaches TIMEOUT with mem_valid=0: bus_err<=1, go to HALTED, ir and pc unchanged.
  - mem_valid and timeout on the same cycle: mem_valid wins.
- DECODE: one cycle, settling time for the combinational decode.
  - If ir==8'hFF, go to HALTED.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - exec_en=1; retired<=retired+1 (wraps).
  - Then go to FETCH if run=1, else IDLE.
- HALTED:
  - halted=1, mem_rd=0; run is ignored.
  - Only clr exits; HALT is not counted in retired.
- Latency: minimum 3 cycles per instruction (FETCH, DECODE, EXEC) with zero-wait memory, plus N extra cycles for N wait states.
- Deasserting run mid-instruction completes that instruction; the sequencer stops in IDLE after EXEC.
- ir changes only in FETCH on mem_valid, so decode outputs are stable during DECODE and EXEC.
- A HALT opcode at the last address (pc wrapped to 0 after fetch) halts normally.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and the PAUSE state.
  - EXEC always goes to PAUSE.
  - PAUSE goes to FETCH on a rising edge of step, detected by a registered previous value. A step held high advances only one instruction.
  - run=0 in PAUSE goes to IDLE.
  - clr also clears the step edge register.
- When undefined: no step port; EXEC transitions exactly as in Behaviour; PAUSE is unreachable.

Test Plan:
- Reset/idle: clr=1 for 1 cycle, then run=0 for 10 cycles -> state=0, pc=0, ir=0, mem_rd=0, retired=0 throughout.
- Straight-line program, zero-wait memory: bytes {8'h05, 8'h6B, 8'h84, 8'hFF} at addresses 0..3, run=1 ->
  - ir takes values 05, 6B, 84, FF; exec_en pulses exactly 3 times, 3 cycles apart.
  - halted=1 with pc=4, retired=3.
  - run toggling afterwards has no effect.
- Wait states: same program with 2 wait cycles per fetch -> exec_en pulses 5 cycles apart; ir is stable from DECODE through EXEC of each instruction.
- Timeout: mem_valid never asserted, TIMEOUT=15 -> after 15 FETCH cycles bus_err=1, halted=1, pc=0. clr then returns to IDLE with bus_err=0.
- Reset mid-operation and run drop:
  - clr asserted during FETCH with mem_valid=1 -> IDLE, ir=0, pc=0 (clr wins).
  - Separately, run dropped during DECODE of 8'h05 -> EXEC still pulses, then state=IDLE with pc=1.
- PC wrap, ADDR_W=2: bytes {01, 02, 03, 04} looping, run=1 -> pc sequence 1, 2, 3, 0, 1, and retired increments every instruction.
  - With SEQ_SINGLE_STEP_EN: the sequencer stops in PAUSE after each EXEC; one step pulse gives exactly one more exec_en; a step held high 10 cycles still gives one.
